// File: rtl/output_display_driver.sv
// rtl/output_display_driver.sv - byte to BCD converter with multiplexed 4-digit seven-segment drive
module output_display_driver #(
  parameter int REFRESH_DIV = 16
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [7:0]  RawOutput,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [11:0] value_bcd,
  output logic        busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] LATCH   = 2'd2;

  localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    captured_q, captured_d;
  logic [7:0]    shift_q, shift_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [2:0]    step_q, step_d;
  logic [11:0]   value_bcd_q, value_bcd_d;
  logic [11:0]   disp_q, disp_d;
  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;
  logic [11:0]   bcd_adj;
  logic [3:0]    digit_val;
  logic          digit_blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Double-dabble correction: bump every nibble >= 5 before the shift
  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  end

  // Conversion FSM: capture on change, shift 8 times, latch result
  always_comb begin
    state_d     = state_q;
    captured_d  = captured_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    step_d      = step_q;
    value_bcd_d = value_bcd_q;
    disp_d      = disp_q;
    case (state_q)
      IDLE: begin
        if (RawOutput != captured_q) begin
          captured_d = RawOutput;
          shift_d    = RawOutput;
          bcd_d      = 12'd0;
          step_d     = 3'd0;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d   = {bcd_adj[10:0], shift_q[7]};
        shift_d = {shift_q[6:0], 1'b0};
        step_d  = step_q + 3'd1;
        if (step_q == 3'd7) state_d = LATCH;
      end
      LATCH: begin
        value_bcd_d = bcd_q;
        disp_d      = bcd_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running digit scan, independent of the conversion FSM
  always_comb begin
    refresh_d = refresh_q + CW'(1);
    digit_d   = digit_q;
    if (refresh_q == REF_MAX) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end
  end

  // Digit select and leading-zero blanking from registered state only
  always_comb begin
    digit_val   = disp_q[3:0];
    digit_blank = 1'b0;
    case (digit_q)
      2'd0: digit_val = disp_q[3:0];
      2'd1: begin
        digit_val   = disp_q[7:4];
        digit_blank = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit_val   = disp_q[11:8];
        digit_blank = (disp_q[11:8] == 4'd0);
      end
      default: digit_blank = 1'b1;
    endcase
    an        = ~(4'b0001 << digit_q);
    seg       = digit_blank ? 7'b1111111 : seg_of(digit_val);
    busy      = (state_q != IDLE);
    value_bcd = value_bcd_q;
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      captured_q  <= '0;
      shift_q     <= '0;
      bcd_q       <= '0;
      step_q      <= '0;
      value_bcd_q <= '0;
      disp_q      <= '0;
      refresh_q   <= '0;
      digit_q     <= '0;
    end else begin
      state_q     <= state_d;
      captured_q  <= captured_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      step_q      <= step_d;
      value_bcd_q <= value_bcd_d;
      disp_q      <= disp_d;
      refresh_q   <= refresh_d;
      digit_q     <= digit_d;
    end
  end

endmodule

// File: tb/tb_output_display_driver.sv
// tb/tb_output_display_driver.sv - scoreboard bench for output_display_driver
module tb_output_display_driver;

  logic        clk;
  logic        Reset;
  logic [7:0]  RawOutput;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [11:0] value_bcd;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles = 0;
  logic [11:0] exp_q[$];
  logic prev_busy = 1'b0;

  localparam logic [6:0] BLANK = 7'b1111111;

  output_display_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .Reset(Reset), .RawOutput(RawOutput),
    .seg(seg), .an(an), .value_bcd(value_bcd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a completed conversion shows as busy falling outside reset
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (!Reset && prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {20'd0, value_bcd}, 32'hFFFF_FFFF);
      end else begin
        check("scoreboard_value_bcd", {20'd0, value_bcd}, {20'd0, exp_q.pop_front()});
      end
    end
    prev_busy = busy;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_slot(input int k, input logic [6:0] exp_seg, input string name);
    logic [3:0] want;
    int t;
    want = ~(4'b0001 << k);
    t = 0;
    while (an !== want && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, "_an"}, {28'd0, an}, {28'd0, want});
    check({name, "_seg"}, {25'd0, seg}, {25'd0, exp_seg});
  endtask

  initial begin
    int b0;
    int t;
    logic [3:0] prev_an;
    logic [3:0] an_pat[4];
    an_pat[0] = 4'b1110; an_pat[1] = 4'b1101; an_pat[2] = 4'b1011; an_pat[3] = 4'b0111;

    Reset = 1'b1;
    RawOutput = 8'd0;
    cycles(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_an", {28'd0, an}, 32'b1110);
    check("rst_seg", {25'd0, seg}, 32'b1000000);
    check("rst_value_bcd", {20'd0, value_bcd}, 32'd0);

    // No conversion when input matches the cleared capture register
    Reset = 1'b0;
    b0 = busy_cycles;
    cycles(20);
    check("idle_no_busy", busy_cycles - b0, 0);

    // 255: nine busy cycles, digits 2 5 5
    b0 = busy_cycles;
    RawOutput = 8'd255;
    exp_q.push_back(12'h255);
    cycles(14);
    check("255_busy_cycles", busy_cycles - b0, 9);
    check("255_value_bcd", {20'd0, value_bcd}, 32'h255);
    check_slot(0, 7'b0010010, "255_ones");
    check_slot(1, 7'b0010010, "255_tens");
    check_slot(2, 7'b0100100, "255_hund");
    check_slot(3, BLANK, "255_left");

    // 7: leading zeros blanked
    RawOutput = 8'd7;
    exp_q.push_back(12'h007);
    cycles(14);
    check("7_value_bcd", {20'd0, value_bcd}, 32'h007);
    check_slot(0, 7'b1111000, "7_ones");
    check_slot(1, BLANK, "7_tens");
    check_slot(2, BLANK, "7_hund");

    // 100 then 42 mid-conversion: second conversion follows the first
    RawOutput = 8'd100;
    exp_q.push_back(12'h100);
    exp_q.push_back(12'h042);
    cycles(3);
    RawOutput = 8'd42;
    cycles(30);
    check("42_value_bcd", {20'd0, value_bcd}, 32'h042);
    check_slot(0, 7'b0100100, "42_ones");
    check_slot(1, 7'b0011001, "42_tens");
    check_slot(2, BLANK, "42_hund");

    // Scan order with REFRESH_DIV=4: align to the wrap into slot 0
    prev_an = an;
    t = 0;
    @(negedge clk);
    while (!(prev_an === 4'b0111 && an === 4'b1110) && t < 40) begin
      prev_an = an;
      @(negedge clk);
      t++;
    end
    check("scan_align", {31'd0, (t < 40)}, 32'd1);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("scan_an_%0d", i), {28'd0, an}, {28'd0, an_pat[(i / 4) % 4]});
      @(negedge clk);
    end

    // Reset at the 5th CONVERT edge of 200 discards the partial conversion
    RawOutput = 8'd200;
    cycles(5);
    Reset = 1'b1;
    cycles(1);
    check("midrst_value_bcd", {20'd0, value_bcd}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_an", {28'd0, an}, 32'b1110);
    cycles(1);
    Reset = 1'b0;
    exp_q.push_back(12'h200);
    cycles(14);
    check("200_value_bcd", {20'd0, value_bcd}, 32'h200);

    // Steady input: no further activity
    b0 = busy_cycles;
    cycles(40);
    check("steady_busy", busy_cycles - b0, 0);
    check("steady_value_bcd", {20'd0, value_bcd}, 32'h200);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
